imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 26 ++
 rtl/imm_decode_core.sv | 44 ++++
 rtl/imm_gen_pipe.sv | 81 ++++++++
 tb/tb_imm_gen_pipe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: format encoding and RISC-V opcode constants shared by the immediate generator.
package imm_pkg;
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
endpackage

// File: rtl/imm_decode_core.sv
// imm_decode_core: combinational instruction-format classification and immediate extraction.
module imm_decode_core
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output fmt_t            o_fmt
);
  localparam bit RV64 = (XLEN == 64);
  logic [6:0]  w_op;
  logic [31:0] w_i, w_s, w_b, w_u, w_j, w_imm32;
  assign w_op = i_instr[6:0];
  assign w_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_u  = {i_instr[31:12], 12'b0};
  assign w_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  always_comb begin
    o_fmt = FMT_ILL;
    if (i_instr[1:0] == 2'b11)
      case (w_op)
        OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: o_fmt = FMT_I;
        OP_SYSTEM: o_fmt = (i_instr[14] && EN_ZICSR) ? FMT_Z : FMT_I;
        OP_IMM32:  o_fmt = RV64 ? FMT_I : FMT_ILL;
        OP_STORE:  o_fmt = FMT_S;
        OP_BRANCH: o_fmt = FMT_B;
        OP_LUI, OP_AUIPC: o_fmt = FMT_U;
        OP_JAL:    o_fmt = FMT_J;
        OP_OP:     o_fmt = FMT_R;
        OP_OP32:   o_fmt = RV64 ? FMT_R : FMT_ILL;
        default:   o_fmt = FMT_ILL;
      endcase
  end
  assign w_imm32 = (o_fmt == FMT_I) ? w_i :
                   (o_fmt == FMT_S) ? w_s :
                   (o_fmt == FMT_B) ? w_b :
                   (o_fmt == FMT_U) ? w_u :
                   (o_fmt == FMT_J) ? w_j : 32'd0;
  // All signed formats fit in 32 bits, so one sign-extension covers both XLENs.
  assign o_imm = (o_fmt == FMT_Z) ? XLEN'(i_instr[19:15]) : XLEN'($signed(w_imm32));
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-cycle immediate generator with valid/ready handshake, skid buffer
// and a saturating illegal-instruction counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [15:0]     illegal_cnt
);
  logic [XLEN-1:0] w_imm;
  fmt_t            w_fmt;
  logic            w_in_fire, w_out_load, w_skid_load, w_skid_next;
  logic            r_in_ready, r_out_valid, r_skid_valid;
  logic [31:0]     r_out_instr, r_skid_instr;
  logic [XLEN-1:0] r_out_imm, r_skid_imm;
  fmt_t            r_out_fmt, r_skid_fmt;
  logic [15:0]     r_illegal_cnt;
  imm_decode_core #(.XLEN(XLEN), .EN_ZICSR(EN_ZICSR)) u_core (
    .i_instr (in_instr),
    .o_imm   (w_imm),
    .o_fmt   (w_fmt)
  );
  assign w_in_fire   = in_valid && r_in_ready;
  assign w_out_load  = !r_out_valid || out_ready;
  // in_ready is only high with the skid empty, so the skid never overflows.
  assign w_skid_load = w_in_fire && !w_out_load;
  assign w_skid_next = r_skid_valid ? !w_out_load : w_skid_load;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_imm     <= '0;
      r_out_fmt     <= FMT_R;
      r_skid_valid  <= 1'b0;
      r_skid_instr  <= '0;
      r_skid_imm    <= '0;
      r_skid_fmt    <= FMT_R;
      r_illegal_cnt <= '0;
    end else begin
      if (w_out_load) begin
        r_out_valid <= r_skid_valid || w_in_fire;
        if (r_skid_valid) begin
          r_out_instr <= r_skid_instr;
          r_out_imm   <= r_skid_imm;
          r_out_fmt   <= r_skid_fmt;
        end else if (w_in_fire) begin
          r_out_instr <= in_instr;
          r_out_imm   <= w_imm;
          r_out_fmt   <= w_fmt;
        end
      end
      if (w_skid_load) begin
        r_skid_instr <= in_instr;
        r_skid_imm   <= w_imm;
        r_skid_fmt   <= w_fmt;
      end
      r_skid_valid <= w_skid_next;
      r_in_ready   <= !w_skid_next;
      if (w_in_fire && w_fmt == FMT_ILL && r_illegal_cnt != 16'hFFFF)
        r_illegal_cnt <= r_illegal_cnt + 16'd1;
    end
  end
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out_fmt;
  assign illegal_cnt = r_illegal_cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vector table plus handshake, reset and saturation sequences
// across XLEN=32, XLEN=64 and no-Zicsr instances.
module tb_imm_gen_pipe;
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic        in_ready_a, out_valid_a, in_ready_w, out_valid_w, in_ready_n, out_valid_n;
  logic [31:0] out_instr_a, out_instr_w, out_instr_n, out_imm_a, out_imm_n;
  logic [63:0] out_imm_w;
  logic [2:0]  out_fmt_a, out_fmt_w, out_fmt_n;
  logic [15:0] cnt_a, cnt_w, cnt_n;
  int          n_vec = 0, n_err = 0, exp_cnt = 0;
  vec_t        tbl[$];
  localparam logic [31:0] A = 32'h00100093, B = 32'h00200113, C = 32'h00300193;

  imm_gen_pipe #(.XLEN(32), .EN_ZICSR(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(out_instr_a),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .illegal_cnt(cnt_a));
  imm_gen_pipe #(.XLEN(64), .EN_ZICSR(1'b1)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_instr(in_instr),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_instr(out_instr_w),
    .out_imm(out_imm_w), .out_fmt(out_fmt_w), .illegal_cnt(cnt_w));
  imm_gen_pipe #(.XLEN(32), .EN_ZICSR(1'b0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .in_instr(in_instr),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_instr(out_instr_n),
    .out_imm(out_imm_n), .out_fmt(out_fmt_n), .illegal_cnt(cnt_n));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    tbl.push_back('{32'hFFC12083, 3'd1, 32'hFFFFFFFC});
    tbl.push_back('{32'h00500093, 3'd1, 32'h00000005});
    tbl.push_back('{32'h0FF0000F, 3'd1, 32'h000000FF});
    tbl.push_back('{32'h000080E7, 3'd1, 32'h00000000});
    tbl.push_back('{32'h34011073, 3'd1, 32'h00000340});
    tbl.push_back('{32'hFE20AC23, 3'd2, 32'hFFFFFFF8});
    tbl.push_back('{32'h0020AA23, 3'd2, 32'h00000014});
    tbl.push_back('{32'h00000463, 3'd3, 32'h00000008});
    tbl.push_back('{32'hFE000EE3, 3'd3, 32'hFFFFFFFC});
    tbl.push_back('{32'h000000E3, 3'd3, 32'h00000800});
    tbl.push_back('{32'h12345097, 3'd4, 32'h12345000});
    tbl.push_back('{32'hFFFFF0B7, 3'd4, 32'hFFFFF000});
    tbl.push_back('{32'hFFFFF06F, 3'd5, 32'hFFFFFFFE});
    tbl.push_back('{32'h001000EF, 3'd5, 32'h00000800});
    tbl.push_back('{32'h002081B3, 3'd0, 32'h00000000});
    tbl.push_back('{32'h3401D073, 3'd6, 32'h00000003});
    tbl.push_back('{32'h00500091, 3'd7, 32'h00000000});
    tbl.push_back('{32'h0000003B, 3'd7, 32'h00000000});
    tbl.push_back('{32'h0000001B, 3'd7, 32'h00000000});

    repeat (2) @(negedge clk);
    chk("rst out_valid", out_valid_a, 0);
    chk("rst in_ready", in_ready_a, 0);
    chk("rst cnt", cnt_a, 0);
    chk("rst out_instr", out_instr_a, 0);
    chk("rst out_imm", out_imm_a, 0);
    chk("rst out_fmt", out_fmt_a, 0);
    rst = 1'b0;
    #1 chk("in_ready before first edge", in_ready_a, 0);
    @(negedge clk);
    chk("in_ready after release", in_ready_a, 1);

    send(32'h00000000);
    chk("zero fmt", out_fmt_a, 7);
    chk("zero imm", out_imm_a, 0);
    send(32'hFFFFFFFF);
    chk("ones fmt", out_fmt_a, 7);
    chk("ones imm", out_imm_a, 0);
    chk("illegal cnt 2", cnt_a, 2);
    exp_cnt = 2;

    foreach (tbl[i]) begin
      in_valid = 1'b1;
      in_instr = tbl[i].instr;
      @(negedge clk);
      chk($sformatf("v%0d valid", i), out_valid_a, 1);
      chk($sformatf("v%0d instr", i), out_instr_a, tbl[i].instr);
      chk($sformatf("v%0d fmt", i), out_fmt_a, tbl[i].fmt);
      chk($sformatf("v%0d imm", i), out_imm_a, tbl[i].imm);
      chk($sformatf("v%0d in_ready", i), in_ready_a, 1);
      if (tbl[i].fmt == 3'd7) exp_cnt++;
    end
    in_valid = 1'b0;
    chk("table cnt", cnt_a, exp_cnt);

    send(32'h8000006F);
    chk("rv64 jal fmt", out_fmt_w, 5);
    chk("rv64 jal imm", out_imm_w, 64'hFFFFFFFFFFF00000);
    chk("rv32 jal imm", out_imm_a, 32'hFFF00000);
    send(32'h800000B7);
    chk("rv64 lui fmt", out_fmt_w, 4);
    chk("rv64 lui imm", out_imm_w, 64'hFFFFFFFF80000000);
    send(32'hFFF0009B);
    chk("rv64 addiw fmt", out_fmt_w, 1);
    chk("rv64 addiw imm", out_imm_w, 64'hFFFFFFFFFFFFFFFF);
    chk("rv32 addiw fmt", out_fmt_a, 7);
    send(32'h002080BB);
    chk("rv64 addw fmt", out_fmt_w, 0);
    chk("rv64 addw imm", out_imm_w, 0);
    chk("rv32 addw fmt", out_fmt_a, 7);
    exp_cnt += 2;
    send(32'h3401D073);
    chk("zicsr fmt", out_fmt_a, 6);
    chk("zicsr imm", out_imm_a, 3);
    chk("rv64 zicsr imm", out_imm_w, 3);
    chk("nozicsr fmt", out_fmt_n, 1);
    chk("nozicsr imm", out_imm_n, 32'h340);

    in_valid = 1'b1;
    in_instr = A;
    @(negedge clk);
    out_ready = 1'b0;
    in_instr = B;
    @(negedge clk);
    chk("hold1 instr", out_instr_a, A);
    chk("hold1 in_ready", in_ready_a, 0);
    in_instr = C;
    @(negedge clk);
    chk("hold2 instr", out_instr_a, A);
    chk("hold2 imm", out_imm_a, 1);
    chk("hold2 in_ready", in_ready_a, 0);
    @(negedge clk);
    chk("hold3 instr", out_instr_a, A);
    chk("hold3 valid", out_valid_a, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain B instr", out_instr_a, B);
    chk("drain B imm", out_imm_a, 2);
    chk("drain in_ready", in_ready_a, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain C instr", out_instr_a, C);
    chk("drain C imm", out_imm_a, 3);
    @(negedge clk);
    chk("drain empty", out_valid_a, 0);

    out_ready = 1'b0;
    send(32'h00000000);
    exp_cnt++;
    in_valid = 1'b1;
    in_instr = A;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full in_ready", in_ready_a, 0);
    chk("full out_valid", out_valid_a, 1);
    chk("full cnt", cnt_a, exp_cnt);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", out_valid_a, 0);
    chk("async rst in_ready", in_ready_a, 0);
    chk("async rst cnt", cnt_a, 0);
    chk("async rst instr", out_instr_a, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("post rst in_ready low", in_ready_a, 0);
    @(negedge clk);
    chk("post rst in_ready", in_ready_a, 1);
    chk("post rst out_valid", out_valid_a, 0);
    @(negedge clk);
    chk("skid discarded", out_valid_a, 0);

    in_valid = 1'b1;
    in_instr = 32'h00000000;
    repeat (65534) @(negedge clk);
    chk("cnt FFFE", cnt_a, 16'hFFFE);
    @(negedge clk);
    chk("cnt FFFF", cnt_a, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("cnt saturated", cnt_a, 16'hFFFF);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
